// File: rtl/alu_pkg.sv
// Shared encodings for the digit-serial ALU: op codes, flag bit positions, FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSA = 3'b101,
    OP_ADC   = 3'b110,
    OP_NOTB  = 3'b111
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_digit_serial_if.sv
// Operand/result handshake bundle for the digit-serial ALU.
interface alu_digit_serial_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             a_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a_en, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a_en, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_digit_slice.sv
// One DIGIT-bit ripple slice: B-invert adder plus the bitwise ops, purely combinational.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             binv,
  input  logic             cin,
  input  op_e              op,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT:0]   sum;

  always_comb begin
    bx   = binv ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bx} + {{DIGIT{1'b0}}, cin};
    cout = sum[DIGIT];
    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ c.
    cmsb = sum[DIGIT-1] ^ a[DIGIT-1] ^ bx[DIGIT-1];
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_PASSA: y = a;
      OP_NOTB:  y = ~b;
      default:  y = sum[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/alu_digit_serial.sv
// Multi-cycle ALU: WIDTH-bit op processed DIGIT bits per clock, LSB digit first,
// with valid/ready on both sides, NZCV flags and a carry kept for add-with-carry.
module alu_digit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               reset,
  alu_digit_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("alu_digit_serial: WIDTH must be a multiple of DIGIT, with 1 <= DIGIT <= WIDTH");
  end

  state_e           state;
  logic [CW-1:0]    cnt;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             cy_q, c_q;
  logic [3:0]       flags_q, flags_nxt;
  logic             out_valid_q;
  logic             cin0, last, arith;
  int               idx;
  logic [DIGIT-1:0] a_d, b_d, y_d;
  logic             cout, cmsb;

  assign idx   = DIGIT * int'(cnt);
  assign a_d   = a_q[idx +: DIGIT];
  assign b_d   = b_q[idx +: DIGIT];
  assign last  = (cnt == CW'(N - 1));
  assign arith = is_arith(op_q);

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_d),
    .b    (b_d),
    .binv (op_q == OP_SUB),
    .cin  (cy_q),
    .op   (op_q),
    .y    (y_d),
    .cout (cout),
    .cmsb (cmsb)
  );

  // Carry into digit 0 is chosen at accept time from the incoming op.
  always_comb begin
    case (op_e'(bus.op))
      OP_SUB:  cin0 = 1'b1;
      OP_ADC:  cin0 = c_q;
      default: cin0 = 1'b0;
    endcase
  end

  // Flags see the full result including the digit being written this cycle.
  always_comb begin
    res_nxt               = res_q;
    res_nxt[idx +: DIGIT] = y_d;
    flags_nxt             = '0;
    flags_nxt[FLAG_N]     = res_nxt[WIDTH-1];
    flags_nxt[FLAG_Z]     = ~|res_nxt;
    flags_nxt[FLAG_C]     = arith & cout;
    flags_nxt[FLAG_V]     = arith & (cout ^ cmsb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cy_q        <= 1'b0;
      c_q         <= 1'b0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= op_e'(bus.op);
            a_q   <= bus.a_en ? bus.a : '0;
            b_q   <= bus.b;
            cy_q  <= cin0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_q <= res_nxt;
          cy_q  <= cout;
          if (last) begin
            cnt         <= '0;
            flags_q     <= flags_nxt;
            c_q         <= flags_nxt[FLAG_C];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_digit_serial.sv
// Drives DIGIT=4, 16 and 1 instances with identical stimulus and checks each
// against an arithmetic reference model of the ALU rules.
module tb_alu_digit_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        a_en = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_ready = 1'b0;

  logic [2:0]  ov, ir;
  logic [15:0] res [3];
  logic [3:0]  fl  [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic m_cq  = 1'b0;
  int exp_lat [3] = '{5, 2, 17};
  logic [19:0] got;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : (g == 1) ? 16 : 1;
      alu_digit_serial_if #(.WIDTH(16)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.op        = op;
      assign bus.a_en      = a_en;
      assign bus.a         = a;
      assign bus.b         = b;
      assign bus.out_ready = out_ready;
      assign ov[g]  = bus.out_valid;
      assign ir[g]  = bus.in_ready;
      assign res[g] = bus.result;
      assign fl[g]  = bus.flags;
      alu_digit_serial #(.WIDTH(16), .DIGIT(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {N,Z,C,V, result}, from plain unsigned/signed arithmetic.
  function automatic logic [19:0] model(input logic [2:0] o, input logic en,
                                        input logic [15:0] x, input logic [15:0] y,
                                        input logic cq);
    logic [15:0] ax, r;
    logic c, v;
    int sr, ci;
    int unsigned ur;
    ax = en ? x : 16'h0;
    c = 1'b0; v = 1'b0; r = '0;
    ci = (o == 3'd6 && cq) ? 1 : 0;
    case (o)
      3'd0, 3'd6: begin
        ur = 32'(ax) + 32'(y) + 32'(ci);
        sr = int'($signed(ax)) + int'($signed(y)) + ci;
        r  = ur[15:0];
        c  = ur[16];
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        r  = ax - y;
        c  = (ax >= y);
        sr = int'($signed(ax)) - int'($signed(y));
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = ax & y;
      3'd3: r = ax | y;
      3'd4: r = ax ^ y;
      3'd5: r = ax;
      default: r = ~y;
    endcase
    return {r[15], (r == 16'h0), c, v, r};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic en, input logic [15:0] x,
                       input logic [15:0] y, input int hold, output logic [19:0] g0);
    int lat [3];
    logic [19:0] m;
    for (int d = 0; d < 3; d++) chk($sformatf("pre_in_ready_d%0d", d), 32'(ir[d]), 32'd1);
    @(negedge clk);
    in_valid = 1'b1; op = o; a_en = en; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 3'($urandom); a_en = 1'($urandom);
    m = model(o, en, x, y, m_cq);
    m_cq = m[17];
    lat = '{0, 0, 0};
    for (int cyc = 1; cyc <= 40; cyc++) begin
      for (int d = 0; d < 3; d++) if (ov[d] && lat[d] == 0) lat[d] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("latency_d%0d", d), 32'(lat[d]), 32'(exp_lat[d]));
      chk($sformatf("result_d%0d op%0d", d, o), 32'(res[d]), 32'(m[15:0]));
      chk($sformatf("flags_d%0d op%0d", d, o), 32'(fl[d]), 32'(m[19:16]));
    end
    g0 = {fl[0], res[0]};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = h[0]; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("hold_valid_d%0d", d), 32'(ov[d]), 32'd1);
        chk($sformatf("hold_ready_d%0d", d), 32'(ir[d]), 32'd0);
        chk($sformatf("hold_result_d%0d", d), 32'(res[d]), 32'(m[15:0]));
        chk($sformatf("hold_flags_d%0d", d), 32'(fl[d]), 32'(m[19:16]));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_valid_d%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("post_ready_d%0d", d), 32'(ir[d]), 32'd1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [15:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid_d%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("rst_ready_d%0d", d), 32'(ir[d]), 32'd0);
      chk($sformatf("rst_result_d%0d", d), 32'(res[d]), 32'd0);
      chk($sformatf("rst_flags_d%0d", d), 32'(fl[d]), 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_op(3'd0, 1'b1, 16'h7FFF, 16'h0001, 0, got); chk("tp_add_ovf", 32'(got), 32'h98000);
    do_op(3'd1, 1'b1, 16'h0005, 16'h0005, 0, got); chk("tp_sub_eq", 32'(got), 32'h60000);
    do_op(3'd1, 1'b1, 16'h0000, 16'h0001, 0, got); chk("tp_sub_borrow", 32'(got), 32'h8FFFF);
    do_op(3'd0, 1'b1, 16'hFFFF, 16'h0001, 0, got); chk("tp_add_carry", 32'(got), 32'h60000);
    do_op(3'd6, 1'b1, 16'h0000, 16'h0000, 0, got); chk("tp_adc_one", 32'(got), 32'h00001);
    do_op(3'd6, 1'b1, 16'h0000, 16'h0000, 0, got); chk("tp_adc_zero", 32'(got), 32'h40000);
    do_op(3'd0, 1'b0, 16'h1234, 16'h0F0F, 0, got); chk("tp_aen_off", 32'(got), 32'h00F0F);
    do_op(3'd4, 1'b1, 16'hAAAA, 16'h5555, 10, got); chk("tp_xor_bp", 32'(got), 32'h8FFFF);
    do_op(3'd7, 1'b1, 16'h1234, 16'h00FF, 0, got); chk("tp_notb", 32'(got), 32'h8FF00);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom);
      ra = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
      rb = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
      do_op(ro, ($urandom_range(0, 3) != 0), ra, rb, 0, got);
    end

    // Reset during the second RUN cycle, with a stored carry of 1 beforehand.
    do_op(3'd0, 1'b1, 16'hFFFF, 16'h0001, 0, got);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; a_en = 1'b1; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    m_cq = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_valid_d%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("abort_flags_d%0d", d), 32'(fl[d]), 32'd0);
      chk($sformatf("abort_ready_d%0d", d), 32'(ir[d]), 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    do_op(3'd6, 1'b1, 16'h0000, 16'h0000, 0, got); chk("abort_cq_cleared", 32'(got), 32'h40000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
